// File: rtl/micro_seq_store.sv
// Writable microcode control store with a built-in microsequencer.
// Each fetched word selects the next micro-address (jump, increment, dispatch, branch).
module micro_seq_store #(
    parameter int CTRL_W     = 20,
    parameter int ADDR_W     = 6,
    parameter int OPC_W      = 4,
    parameter int RESET_ADDR = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_mode,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [CTRL_W+ADDR_W+1:0] wr_data,
    input  logic                     stall,
    input  logic                     cond,
    input  logic [OPC_W-1:0]         opcode,
    output logic [CTRL_W+ADDR_W+1:0] micro_op,
    output logic [CTRL_W-1:0]        ctrl,
    output logic [ADDR_W-1:0]        upc,
    output logic                     uop_valid
);

    localparam int W     = CTRL_W + 2 + ADDR_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(RESET_ADDR);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEQ_JUMP     = 2'b00,
        SEQ_INC      = 2'b01,
        SEQ_DISPATCH = 2'b10,
        SEQ_BRANCH   = 2'b11
    } seq_t;

    logic [W-1:0]      r_mem [DEPTH];
    state_t            r_state;
    logic [W-1:0]      r_micro_op;
    logic [ADDR_W-1:0] r_upc;
    logic              r_uop_valid;

    logic [1:0]        w_seq;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_upc_inc;
    logic [ADDR_W-1:0] w_opc_ext;
    logic [ADDR_W-1:0] w_na;

    assign w_seq     = r_micro_op[ADDR_W+1:ADDR_W];
    assign w_next    = r_micro_op[ADDR_W-1:0];
    assign w_upc_inc = r_upc + ADDR_W'(1);
    assign w_opc_ext = ADDR_W'(opcode);

    // Adders are ADDR_W wide, so increment and dispatch wrap modulo the store depth.
    always_comb begin
        w_na = w_next;
        case (w_seq)
            SEQ_JUMP:     w_na = w_next;
            SEQ_INC:      w_na = w_upc_inc;
            SEQ_DISPATCH: w_na = w_next + w_opc_ext;
            SEQ_BRANCH:   w_na = cond ? w_next : w_upc_inc;
            default:      w_na = w_next;
        endcase
    end

    // NOTE: the store has no reset so it maps onto RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking updates mean a fetch of the address being written sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_START;
            r_micro_op  <= '0;
            r_upc       <= START_ADDR;
            r_uop_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    if (load_mode) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_micro_op  <= r_mem[START_ADDR];
                        r_upc       <= START_ADDR;
                        r_uop_valid <= 1'b1;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load_mode) begin
                        r_micro_op  <= '0;
                        r_uop_valid <= 1'b0;
                        r_state     <= ST_LOAD;
                    end else if (!stall) begin
                        r_micro_op <= r_mem[w_na];
                        r_upc      <= w_na;
                    end
                end
                ST_LOAD: begin
                    r_micro_op  <= '0;
                    r_uop_valid <= 1'b0;
                    if (!load_mode) begin
                        r_state <= ST_START;
                    end
                end
                default: begin
                    r_micro_op  <= '0;
                    r_uop_valid <= 1'b0;
                    r_state     <= ST_START;
                end
            endcase
        end
    end

    assign micro_op  = r_micro_op;
    assign ctrl      = r_micro_op[W-1:ADDR_W+2];
    assign upc       = r_upc;
    assign uop_valid = r_uop_valid;

endmodule
